// File: rtl/s_axis_rq_adapt_x4_pkg.sv
// Shared definitions for the x4 RQ requester adapter.
//   - FSM state encoding
//   - RQ req_type codes and legacy fmt/type codes
//   - RQ descriptor field offsets
//   - DW keep helpers
package s_axis_rq_adapt_x4_pkg;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_PASS,
    ST_SHIFT,
    ST_FLUSH,
    ST_DROP
  } rq_state_t;

  localparam logic [3:0] RQ_MRD       = 4'b0000;
  localparam logic [3:0] RQ_MWR       = 4'b0001;
  localparam logic [4:0] LEG_TYPE_MEM = 5'b00000;
  localparam int         FMT_4DW_BIT  = 0;
  localparam int         FMT_DATA_BIT = 1;

  localparam int DESC_ADDR_LSB    = 2;
  localparam int DESC_DWCNT_LSB   = 64;
  localparam int DESC_REQTYPE_LSB = 75;
  localparam int DESC_REQID_LSB   = 80;
  localparam int DESC_TAG_LSB     = 96;
  localparam int DESC_TC_LSB      = 121;
  localparam int DESC_ATTR_LSB    = 124;

  // Number of valid DWs in a beat; keep is assumed contiguous from DW0.
  function automatic logic [2:0] dw_count(input logic [3:0] k);
    if (k[3])      return 3'd4;
    else if (k[2]) return 3'd3;
    else if (k[1]) return 3'd2;
    else           return 3'd1;
  endfunction

  // Contiguous DW keep mask for n DWs (n = 1..4).
  function automatic logic [3:0] dw_mask(input logic [2:0] n);
    case (n)
      3'd1:    return 4'h1;
      3'd2:    return 4'h3;
      3'd3:    return 4'h7;
      default: return 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/rq_descriptor_build.sv
// Combinational legacy-header to RQ-descriptor mapping.
//   hdr       : first legacy beat (header DW0 in [31:0])
//   desc      : 128-bit RQ descriptor
//   supported : memory request (MRd/MWr)
//   is_mwr    : request carries payload
//   is_4dw    : 4DW (64-bit address) header
//   be        : {last_be, first_be}
module rq_descriptor_build
  import s_axis_rq_adapt_x4_pkg::*;
(
  input  logic [127:0] hdr,
  output logic [127:0] desc,
  output logic         supported,
  output logic         is_mwr,
  output logic         is_4dw,
  output logic [7:0]   be
);

  logic [2:0]  fmt;
  logic [4:0]  typ;
  logic [9:0]  len;
  logic [61:0] addr;
  logic        unused_hdr;

  assign fmt       = hdr[31:29];
  assign typ       = hdr[28:24];
  assign len       = hdr[9:0];
  assign is_4dw    = fmt[FMT_4DW_BIT];
  assign is_mwr    = fmt[FMT_DATA_BIT];
  assign supported = (typ == LEG_TYPE_MEM);
  assign be        = hdr[39:32];
  // DW address: 4DW carries {hi, lo}, 3DW only lo.
  assign addr      = is_4dw ? {hdr[95:64], hdr[127:98]} : {32'b0, hdr[95:66]};

  always_comb begin
    desc = '0;
    desc[DESC_ADDR_LSB    +: 62] = addr;
    desc[DESC_DWCNT_LSB   +: 11] = {len == 10'd0, len};
    desc[DESC_REQTYPE_LSB +: 4]  = is_mwr ? RQ_MWR : RQ_MRD;
    desc[DESC_REQID_LSB   +: 16] = hdr[63:48];
    desc[DESC_TAG_LSB     +: 8]  = hdr[47:40];
    desc[DESC_TC_LSB      +: 3]  = hdr[22:20];
    desc[DESC_ATTR_LSB    +: 3]  = {1'b0, hdr[13:12]};
  end

  assign unused_hdr = ^{fmt[2], hdr[23], hdr[19:14], hdr[11:10], hdr[97:96]};

endmodule

// File: rtl/s_axis_rq_adapt_x4.sv
// Transmit requester adapter, legacy TLP stream -> UltraScale+ RQ, 128-bit.
//   user_clk / user_reset   : clock, synchronous active-high reset
//   s_axis_rq_t*            : legacy TLP input (header + payload)
//   s_axis_rq_t*_a          : RQ output (descriptor beat, then DW-aligned payload)
//   s_axis_rq_tready_a[0]   : core ready
// 3DW MWr payload starts in DW3 of the header beat, so it is realigned by
// one DW through a hold register; a trailing DW may need an extra FLUSH beat.
module s_axis_rq_adapt_x4
  import s_axis_rq_adapt_x4_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  user_clk,
  input  logic                  user_reset,
  input  logic [DATA_WIDTH-1:0] s_axis_rq_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_rq_tkeep,
  input  logic                  s_axis_rq_tlast,
  input  logic                  s_axis_rq_tvalid,
  output logic                  s_axis_rq_tready,
  output logic [DATA_WIDTH-1:0] s_axis_rq_tdata_a,
  output logic [3:0]            s_axis_rq_tkeep_a,
  output logic                  s_axis_rq_tlast_a,
  output logic [59:0]           s_axis_rq_tuser_a,
  output logic                  s_axis_rq_tvalid_a,
  input  logic [3:0]            s_axis_rq_tready_a
);

  rq_state_t    state;
  logic [31:0]  hold;
  logic         advance;
  logic [3:0]   in_dw_keep;
  logic [2:0]   in_dw_cnt;
  logic [127:0] desc;
  logic         hdr_supported;
  logic         hdr_is_mwr;
  logic         hdr_is_4dw;
  logic [7:0]   hdr_be;
  logic         unused_in;

  rq_descriptor_build u_desc (
    .hdr       (s_axis_rq_tdata),
    .desc      (desc),
    .supported (hdr_supported),
    .is_mwr    (hdr_is_mwr),
    .is_4dw    (hdr_is_4dw),
    .be        (hdr_be)
  );

  assign advance          = !s_axis_rq_tvalid_a || s_axis_rq_tready_a[0];
  assign s_axis_rq_tready = advance && (state != ST_FLUSH);
  assign in_dw_keep       = {s_axis_rq_tkeep[12], s_axis_rq_tkeep[8],
                             s_axis_rq_tkeep[4], s_axis_rq_tkeep[0]};
  assign in_dw_cnt        = dw_count(in_dw_keep);

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state              <= ST_HDR;
      hold               <= '0;
      s_axis_rq_tvalid_a <= 1'b0;
      s_axis_rq_tlast_a  <= 1'b0;
      s_axis_rq_tdata_a  <= '0;
      s_axis_rq_tkeep_a  <= '0;
      s_axis_rq_tuser_a  <= '0;
    end else if (advance) begin
      s_axis_rq_tvalid_a <= 1'b0;
      case (state)
        ST_HDR: if (s_axis_rq_tvalid) begin
          if (!hdr_supported) begin
            state <= s_axis_rq_tlast ? ST_HDR : ST_DROP;
          end else begin
            s_axis_rq_tvalid_a <= 1'b1;
            s_axis_rq_tdata_a  <= desc;
            s_axis_rq_tkeep_a  <= 4'hF;
            s_axis_rq_tlast_a  <= !hdr_is_mwr;
            // BEs held for the whole request
            s_axis_rq_tuser_a  <= {52'b0, hdr_be};
            if (hdr_is_mwr) begin
              if (hdr_is_4dw) begin
                state <= ST_PASS;
              end else begin
                hold  <= s_axis_rq_tdata[127:96];
                state <= s_axis_rq_tlast ? ST_FLUSH : ST_SHIFT;
              end
            end
          end
        end
        ST_PASS: if (s_axis_rq_tvalid) begin
          s_axis_rq_tvalid_a <= 1'b1;
          s_axis_rq_tdata_a  <= s_axis_rq_tdata;
          s_axis_rq_tkeep_a  <= in_dw_keep;
          s_axis_rq_tlast_a  <= s_axis_rq_tlast;
          if (s_axis_rq_tlast) state <= ST_HDR;
        end
        ST_SHIFT: if (s_axis_rq_tvalid) begin
          s_axis_rq_tvalid_a <= 1'b1;
          s_axis_rq_tdata_a  <= {s_axis_rq_tdata[95:0], hold};
          hold               <= s_axis_rq_tdata[127:96];
          if (s_axis_rq_tlast && in_dw_cnt != 3'd4) begin
            s_axis_rq_tkeep_a <= dw_mask(in_dw_cnt + 3'd1);
            s_axis_rq_tlast_a <= 1'b1;
            state             <= ST_HDR;
          end else begin
            // full last beat leaves one DW in hold for a FLUSH beat
            s_axis_rq_tkeep_a <= 4'hF;
            s_axis_rq_tlast_a <= 1'b0;
            if (s_axis_rq_tlast) state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          s_axis_rq_tvalid_a <= 1'b1;
          s_axis_rq_tdata_a  <= {96'b0, hold};
          s_axis_rq_tkeep_a  <= 4'h1;
          s_axis_rq_tlast_a  <= 1'b1;
          state              <= ST_HDR;
        end
        ST_DROP: if (s_axis_rq_tvalid && s_axis_rq_tlast) state <= ST_HDR;
        default: state <= ST_HDR;
      endcase
    end
  end

  assign unused_in = ^{s_axis_rq_tready_a[3:1],
                       s_axis_rq_tkeep[15:13], s_axis_rq_tkeep[11:9],
                       s_axis_rq_tkeep[7:5], s_axis_rq_tkeep[3:1]};

endmodule

// File: tb/tb_s_axis_rq_adapt_x4.sv
module tb_s_axis_rq_adapt_x4;

  typedef logic [192:0] beat_t;  // {tdata, tkeep, tlast, tuser}

  logic         user_clk = 1'b0;
  logic         user_reset;
  logic [127:0] s_axis_rq_tdata;
  logic [15:0]  s_axis_rq_tkeep;
  logic         s_axis_rq_tlast;
  logic         s_axis_rq_tvalid;
  logic         s_axis_rq_tready;
  logic [127:0] s_axis_rq_tdata_a;
  logic [3:0]   s_axis_rq_tkeep_a;
  logic         s_axis_rq_tlast_a;
  logic [59:0]  s_axis_rq_tuser_a;
  logic         s_axis_rq_tvalid_a;
  logic [3:0]   s_axis_rq_tready_a;

  int    n_cmp = 0;
  int    n_err = 0;
  int    stall_cnt = 0;
  int    bp_mode = 0;  // 0 ready, 1 random, 2 stalled
  beat_t got[$];

  s_axis_rq_adapt_x4 dut (
    .user_clk           (user_clk),
    .user_reset         (user_reset),
    .s_axis_rq_tdata    (s_axis_rq_tdata),
    .s_axis_rq_tkeep    (s_axis_rq_tkeep),
    .s_axis_rq_tlast    (s_axis_rq_tlast),
    .s_axis_rq_tvalid   (s_axis_rq_tvalid),
    .s_axis_rq_tready   (s_axis_rq_tready),
    .s_axis_rq_tdata_a  (s_axis_rq_tdata_a),
    .s_axis_rq_tkeep_a  (s_axis_rq_tkeep_a),
    .s_axis_rq_tlast_a  (s_axis_rq_tlast_a),
    .s_axis_rq_tuser_a  (s_axis_rq_tuser_a),
    .s_axis_rq_tvalid_a (s_axis_rq_tvalid_a),
    .s_axis_rq_tready_a (s_axis_rq_tready_a)
  );

  always #5 user_clk = ~user_clk;

  initial begin
    s_axis_rq_tready_a = 4'hF;
    forever begin
      @(posedge user_clk); #1;
      case (bp_mode)
        1:       s_axis_rq_tready_a = {3'b0, 1'($urandom_range(0, 1))};
        2:       s_axis_rq_tready_a = 4'h0;
        default: s_axis_rq_tready_a = 4'hF;
      endcase
    end
  end

  // Output beats that transfer on the next rising edge.
  always @(negedge user_clk)
    if (!user_reset && s_axis_rq_tvalid_a && s_axis_rq_tready_a[0])
      got.push_back({s_axis_rq_tdata_a, s_axis_rq_tkeep_a, s_axis_rq_tlast_a, s_axis_rq_tuser_a});

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // ---- model helpers ----
  function automatic logic [31:0] dw0(input logic [2:0] fmt, input logic [4:0] typ,
                                      input logic [2:0] tc, input logic [1:0] attr,
                                      input logic [9:0] len);
    return {fmt, typ, 1'b0, tc, 4'b0, 2'b0, attr, 2'b0, len};
  endfunction

  function automatic logic [31:0] dw1(input logic [15:0] reqid, input logic [7:0] tag,
                                      input logic [7:0] be);
    return {reqid, tag, be};
  endfunction

  function automatic logic [127:0] mk_desc(input logic [63:0] addr, input logic [9:0] len,
                                           input logic [3:0] rt, input logic [15:0] reqid,
                                           input logic [7:0] tag, input logic [2:0] tc,
                                           input logic [1:0] attr);
    logic [10:0] c;
    c = (len == 10'd0) ? 11'd1024 : {1'b0, len};
    return {2'b0, attr, tc, 1'b0, 16'b0, tag, reqid, 1'b0, rt, c, addr[63:2], 2'b0};
  endfunction

  function automatic beat_t bt(input logic [127:0] d, input logic [3:0] k,
                               input logic l, input logic [7:0] be);
    return {d, k, l, 52'b0, be};
  endfunction

  function automatic logic [31:0] dd(input int i);
    return 32'hD000_0000 + 32'(i);
  endfunction

  task automatic send(input logic [127:0] d, input logic [15:0] k, input logic l);
    int w;
    w = 0;
    s_axis_rq_tdata  = d;
    s_axis_rq_tkeep  = k;
    s_axis_rq_tlast  = l;
    s_axis_rq_tvalid = 1'b1;
    @(negedge user_clk);
    while (!s_axis_rq_tready && w < 200) begin
      w++;
      @(negedge user_clk);
    end
    stall_cnt += w;
    if (w >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout tready stayed %b, required 1", s_axis_rq_tready);
    end
    @(posedge user_clk); #1;
    s_axis_rq_tvalid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    repeat (3) @(negedge user_clk);
    while (s_axis_rq_tvalid_a && w < 300) begin
      w++;
      @(negedge user_clk);
    end
    if (w >= 300) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout tvalid_a stayed %b, required 0", s_axis_rq_tvalid_a);
    end
    @(posedge user_clk); #1;
  endtask

  // ---- tests ----
  task automatic test_reset();
    @(negedge user_clk);
    n_cmp++; if (s_axis_rq_tvalid_a !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got %b want 0", s_axis_rq_tvalid_a); end
    n_cmp++; if (s_axis_rq_tlast_a !== 1'b0) begin n_err++; $display("FAIL reset_tlast got %b want 0", s_axis_rq_tlast_a); end
    n_cmp++; if (s_axis_rq_tdata_a !== 128'b0) begin n_err++; $display("FAIL reset_tdata got %h want 0", s_axis_rq_tdata_a); end
    n_cmp++; if (s_axis_rq_tkeep_a !== 4'h0) begin n_err++; $display("FAIL reset_tkeep got %h want 0", s_axis_rq_tkeep_a); end
    n_cmp++; if (s_axis_rq_tuser_a !== 60'b0) begin n_err++; $display("FAIL reset_tuser got %h want 0", s_axis_rq_tuser_a); end
    @(posedge user_clk); #1;
    user_reset = 1'b0;
    @(negedge user_clk);
    n_cmp++; if (s_axis_rq_tready !== 1'b1) begin n_err++; $display("FAIL reset_tready got %b want 1", s_axis_rq_tready); end
    @(posedge user_clk); #1;
  endtask

  task automatic test_mrd32();
    beat_t exp[$];
    int b;
    b = got.size();
    send({32'h0, 32'h1000_0040, dw1(16'hBEEF, 8'h15, 8'hFF), dw0(3'b000, 5'h0, 3'd3, 2'b10, 10'd2)},
         16'h0FFF, 1'b1);
    drain();
    exp.push_back(bt(mk_desc(64'h1000_0040, 10'd2, 4'b0000, 16'hBEEF, 8'h15, 3'd3, 2'b10), 4'hF, 1'b1, 8'hFF));
    n_cmp++; if (got.size() - b !== exp.size()) begin n_err++; $display("FAIL mrd32_count got %0d want %0d", got.size() - b, exp.size()); end
    for (int i = 0; i < exp.size() && b + i < got.size(); i++) begin
      n_cmp++; if (got[b+i] !== exp[i]) begin n_err++; $display("FAIL mrd32_beat%0d got %h want %h", i, got[b+i], exp[i]); end
    end
  endtask

  task automatic test_mwr32_len1_flush();
    beat_t exp[$];
    logic [127:0] d;
    int b;
    b = got.size();
    d = mk_desc(64'h2000_0000, 10'd1, 4'b0001, 16'h0100, 8'h01, 3'd0, 2'b00);
    bp_mode = 2;
    repeat (2) begin @(posedge user_clk); #1; end
    send({32'hA5A5_A5A5, 32'h2000_0000, dw1(16'h0100, 8'h01, 8'h0F), dw0(3'b010, 5'h0, 3'd0, 2'b00, 10'd1)},
         16'hFFFF, 1'b1);
    repeat (3) @(negedge user_clk);
    n_cmp++; if (s_axis_rq_tready !== 1'b0) begin n_err++; $display("FAIL flush_tready got %b want 0", s_axis_rq_tready); end
    n_cmp++; if (s_axis_rq_tvalid_a !== 1'b1) begin n_err++; $display("FAIL flush_hold_valid got %b want 1", s_axis_rq_tvalid_a); end
    n_cmp++; if (s_axis_rq_tdata_a !== d) begin n_err++; $display("FAIL flush_hold_data got %h want %h", s_axis_rq_tdata_a, d); end
    @(posedge user_clk); #1;
    bp_mode = 0;
    drain();
    exp.push_back(bt(d, 4'hF, 1'b0, 8'h0F));
    exp.push_back(bt({96'b0, 32'hA5A5_A5A5}, 4'h1, 1'b1, 8'h0F));
    n_cmp++; if (got.size() - b !== exp.size()) begin n_err++; $display("FAIL mwr32_len1_count got %0d want %0d", got.size() - b, exp.size()); end
    for (int i = 0; i < exp.size() && b + i < got.size(); i++) begin
      n_cmp++; if (got[b+i] !== exp[i]) begin n_err++; $display("FAIL mwr32_len1_beat%0d got %h want %h", i, got[b+i], exp[i]); end
    end
  endtask

  task automatic test_mwr32_len7();
    beat_t exp[$];
    int b;
    b = got.size();
    send({dd(0), 32'h3000_0100, dw1(16'h0200, 8'h22, 8'hFF), dw0(3'b010, 5'h0, 3'd0, 2'b00, 10'd7)}, 16'hFFFF, 1'b0);
    send({dd(4), dd(3), dd(2), dd(1)}, 16'hFFFF, 1'b0);
    send({64'b0, dd(6), dd(5)}, 16'h00FF, 1'b1);
    drain();
    exp.push_back(bt(mk_desc(64'h3000_0100, 10'd7, 4'b0001, 16'h0200, 8'h22, 3'd0, 2'b00), 4'hF, 1'b0, 8'hFF));
    exp.push_back(bt({dd(3), dd(2), dd(1), dd(0)}, 4'hF, 1'b0, 8'hFF));
    exp.push_back(bt({32'b0, dd(6), dd(5), dd(4)}, 4'h7, 1'b1, 8'hFF));
    n_cmp++; if (got.size() - b !== exp.size()) begin n_err++; $display("FAIL mwr32_len7_count got %0d want %0d", got.size() - b, exp.size()); end
    for (int i = 0; i < exp.size() && b + i < got.size(); i++) begin
      n_cmp++; if (got[b+i] !== exp[i]) begin n_err++; $display("FAIL mwr32_len7_beat%0d got %h want %h", i, got[b+i], exp[i]); end
    end
  endtask

  task automatic test_mwr32_len5();
    beat_t exp[$];
    int b;
    b = got.size();
    send({dd(0), 32'h4000_0000, dw1(16'h0300, 8'h33, 8'hFF), dw0(3'b010, 5'h0, 3'd0, 2'b00, 10'd5)}, 16'hFFFF, 1'b0);
    send({dd(4), dd(3), dd(2), dd(1)}, 16'hFFFF, 1'b1);
    drain();
    exp.push_back(bt(mk_desc(64'h4000_0000, 10'd5, 4'b0001, 16'h0300, 8'h33, 3'd0, 2'b00), 4'hF, 1'b0, 8'hFF));
    exp.push_back(bt({dd(3), dd(2), dd(1), dd(0)}, 4'hF, 1'b0, 8'hFF));
    exp.push_back(bt({96'b0, dd(4)}, 4'h1, 1'b1, 8'hFF));
    n_cmp++; if (got.size() - b !== exp.size()) begin n_err++; $display("FAIL mwr32_len5_count got %0d want %0d", got.size() - b, exp.size()); end
    for (int i = 0; i < exp.size() && b + i < got.size(); i++) begin
      n_cmp++; if (got[b+i] !== exp[i]) begin n_err++; $display("FAIL mwr32_len5_beat%0d got %h want %h", i, got[b+i], exp[i]); end
    end
  endtask

  task automatic test_mwr64_pass();
    beat_t exp[$];
    int b;
    b = got.size();
    send({32'h2345_6780, 32'h0000_0001, dw1(16'h0400, 8'h44, 8'hFF), dw0(3'b011, 5'h0, 3'd0, 2'b00, 10'd4)}, 16'hFFFF, 1'b0);
    send({dd(3), dd(2), dd(1), dd(0)}, 16'hFFFF, 1'b1);
    drain();
    exp.push_back(bt(mk_desc(64'h1_2345_6780, 10'd4, 4'b0001, 16'h0400, 8'h44, 3'd0, 2'b00), 4'hF, 1'b0, 8'hFF));
    exp.push_back(bt({dd(3), dd(2), dd(1), dd(0)}, 4'hF, 1'b1, 8'hFF));
    n_cmp++; if (got.size() - b !== exp.size()) begin n_err++; $display("FAIL mwr64_count got %0d want %0d", got.size() - b, exp.size()); end
    for (int i = 0; i < exp.size() && b + i < got.size(); i++) begin
      n_cmp++; if (got[b+i] !== exp[i]) begin n_err++; $display("FAIL mwr64_beat%0d got %h want %h", i, got[b+i], exp[i]); end
    end
  endtask

  task automatic test_backpressure();
    beat_t exp[$];
    int b;
    b = got.size();
    bp_mode = 1;
    send({dd(0), 32'h5000_0000, dw1(16'h0500, 8'h55, 8'hFF), dw0(3'b010, 5'h0, 3'd0, 2'b00, 10'd8)}, 16'hFFFF, 1'b0);
    send({dd(4), dd(3), dd(2), dd(1)}, 16'hFFFF, 1'b0);
    send({32'b0, dd(7), dd(6), dd(5)}, 16'h0FFF, 1'b1);
    drain();
    bp_mode = 0;
    exp.push_back(bt(mk_desc(64'h5000_0000, 10'd8, 4'b0001, 16'h0500, 8'h55, 3'd0, 2'b00), 4'hF, 1'b0, 8'hFF));
    exp.push_back(bt({dd(3), dd(2), dd(1), dd(0)}, 4'hF, 1'b0, 8'hFF));
    exp.push_back(bt({dd(7), dd(6), dd(5), dd(4)}, 4'hF, 1'b1, 8'hFF));
    n_cmp++; if (got.size() - b !== exp.size()) begin n_err++; $display("FAIL bp_count got %0d want %0d", got.size() - b, exp.size()); end
    for (int i = 0; i < exp.size() && b + i < got.size(); i++) begin
      n_cmp++; if (got[b+i] !== exp[i]) begin n_err++; $display("FAIL bp_beat%0d got %h want %h", i, got[b+i], exp[i]); end
    end
  endtask

  task automatic test_drop();
    beat_t exp[$];
    int b;
    b = got.size();
    // CfgRd0, single beat
    send({32'h0, 32'h0000_0010, dw1(16'h0600, 8'h60, 8'h0F), dw0(3'b000, 5'b00100, 3'd0, 2'b00, 10'd1)}, 16'h0FFF, 1'b0 | 1'b1);
    // Msg with data, two beats
    send({32'h0, 32'h0, dw1(16'h0600, 8'h61, 8'h00), dw0(3'b011, 5'b10000, 3'd0, 2'b00, 10'd4)}, 16'hFFFF, 1'b0);
    send({dd(3), dd(2), dd(1), dd(0)}, 16'hFFFF, 1'b1);
    // MRd with len 0 (1024 DWs)
    send({32'h0, 32'h6000_0000, dw1(16'h0600, 8'h66, 8'hFF), dw0(3'b000, 5'h0, 3'd7, 2'b11, 10'd0)}, 16'h0FFF, 1'b1);
    drain();
    exp.push_back(bt(mk_desc(64'h6000_0000, 10'd0, 4'b0000, 16'h0600, 8'h66, 3'd7, 2'b11), 4'hF, 1'b1, 8'hFF));
    n_cmp++; if (got.size() - b !== exp.size()) begin n_err++; $display("FAIL drop_count got %0d want %0d", got.size() - b, exp.size()); end
    for (int i = 0; i < exp.size() && b + i < got.size(); i++) begin
      n_cmp++; if (got[b+i] !== exp[i]) begin n_err++; $display("FAIL drop_beat%0d got %h want %h", i, got[b+i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    beat_t exp[$];
    int b;
    send({dd(0), 32'h3000_0100, dw1(16'h0200, 8'h22, 8'hFF), dw0(3'b010, 5'h0, 3'd0, 2'b00, 10'd7)}, 16'hFFFF, 1'b0);
    send({dd(4), dd(3), dd(2), dd(1)}, 16'hFFFF, 1'b0);
    user_reset = 1'b1;
    repeat (2) begin @(posedge user_clk); #1; end
    user_reset = 1'b0;
    @(negedge user_clk);
    n_cmp++; if (s_axis_rq_tvalid_a !== 1'b0) begin n_err++; $display("FAIL rstmid_tvalid got %b want 0", s_axis_rq_tvalid_a); end
    n_cmp++; if (s_axis_rq_tuser_a !== 60'b0) begin n_err++; $display("FAIL rstmid_tuser got %h want 0", s_axis_rq_tuser_a); end
    @(posedge user_clk); #1;
    b = got.size();
    send({32'h0, 32'h7000_0000, dw1(16'h0700, 8'h77, 8'h0F), dw0(3'b000, 5'h0, 3'd0, 2'b00, 10'd1)}, 16'h0FFF, 1'b1);
    drain();
    exp.push_back(bt(mk_desc(64'h7000_0000, 10'd1, 4'b0000, 16'h0700, 8'h77, 3'd0, 2'b00), 4'hF, 1'b1, 8'h0F));
    n_cmp++; if (got.size() - b !== exp.size()) begin n_err++; $display("FAIL rstmid_count got %0d want %0d", got.size() - b, exp.size()); end
    for (int i = 0; i < exp.size() && b + i < got.size(); i++) begin
      n_cmp++; if (got[b+i] !== exp[i]) begin n_err++; $display("FAIL rstmid_beat%0d got %h want %h", i, got[b+i], exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    beat_t exp[$];
    int b;
    b = got.size();
    stall_cnt = 0;
    send({32'h0, 32'h8000_0004, dw1(16'h0800, 8'h88, 8'h0F), dw0(3'b000, 5'h0, 3'd0, 2'b00, 10'd1)}, 16'h0FFF, 1'b1);
    send({32'h0000_0010, 32'h0000_0009, dw1(16'h0800, 8'h89, 8'hFF), dw0(3'b011, 5'h0, 3'd0, 2'b00, 10'd4)}, 16'hFFFF, 1'b0);
    send({dd(3), dd(2), dd(1), dd(0)}, 16'hFFFF, 1'b1);
    send({32'h0, 32'h8000_0008, dw1(16'h0800, 8'h8A, 8'h0F), dw0(3'b000, 5'h0, 3'd0, 2'b00, 10'd1)}, 16'h0FFF, 1'b1);
    drain();
    n_cmp++; if (stall_cnt !== 0) begin n_err++; $display("FAIL b2b_stalls got %0d want 0", stall_cnt); end
    exp.push_back(bt(mk_desc(64'h8000_0004, 10'd1, 4'b0000, 16'h0800, 8'h88, 3'd0, 2'b00), 4'hF, 1'b1, 8'h0F));
    exp.push_back(bt(mk_desc(64'h9_0000_0010, 10'd4, 4'b0001, 16'h0800, 8'h89, 3'd0, 2'b00), 4'hF, 1'b0, 8'hFF));
    exp.push_back(bt({dd(3), dd(2), dd(1), dd(0)}, 4'hF, 1'b1, 8'hFF));
    exp.push_back(bt(mk_desc(64'h8000_0008, 10'd1, 4'b0000, 16'h0800, 8'h8A, 3'd0, 2'b00), 4'hF, 1'b1, 8'h0F));
    n_cmp++; if (got.size() - b !== exp.size()) begin n_err++; $display("FAIL b2b_count got %0d want %0d", got.size() - b, exp.size()); end
    for (int i = 0; i < exp.size() && b + i < got.size(); i++) begin
      n_cmp++; if (got[b+i] !== exp[i]) begin n_err++; $display("FAIL b2b_beat%0d got %h want %h", i, got[b+i], exp[i]); end
    end
  endtask

  initial begin
    user_reset       = 1'b1;
    s_axis_rq_tdata  = '0;
    s_axis_rq_tkeep  = '0;
    s_axis_rq_tlast  = 1'b0;
    s_axis_rq_tvalid = 1'b0;
    repeat (3) @(posedge user_clk);
    #1;
    test_reset();
    test_mrd32();
    test_mwr32_len1_flush();
    test_mwr32_len7();
    test_mwr32_len5();
    test_mwr64_pass();
    test_backpressure();
    test_drop();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
